// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, with a registered carry.
// Operands load in parallel on an accepted start; sum/carry publish with a one-cycle done pulse.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic              c_q, c_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;

    logic              p, g1, s, g2, c_next;
    logic [WIDTH-1:0]  sa_shift, sb_shift, sr_shift;

    // Full adder from two half adders plus OR; shifted register images for the RUN step.
    always_comb begin
        p        = sa_q[0] ^ sb_q[0];
        g1       = sa_q[0] & sb_q[0];
        s        = p ^ c_q;
        g2       = p & c_q;
        c_next   = g1 | g2;
        sa_shift = sa_q >> 1;
        sb_shift = sb_q >> 1;
        // Written as shift-then-insert so WIDTH=1 needs no special case.
        sr_shift = sr_q >> 1;
        sr_shift[WIDTH-1] = s;
    end

    // Next-state logic: start accepted in IDLE or DONE, WIDTH RUN cycles, then publish.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sr_d    = sr_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                sr_d  = sr_shift;
                sa_d  = sa_shift;
                sb_d  = sb_shift;
                c_d   = c_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    sum_d   = sr_shift;
                    carry_d = c_next;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register with synchronous reset; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sr_q    <= sr_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        busy  = (state_q == StRun);
        done  = (state_q == StDone);
        sum   = sum_q;
        carry = carry_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=1.
// The model tracks accept edges and expected results; a negedge monitor checks every cycle.
module tb_serial_adder;

    localparam int W8 = 8;
    localparam int W1 = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy8, done8, carry8;
    logic [7:0] sum8;
    logic       busy1, done1, carry1;
    logic [0:0] sum1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    // Model state: edge index of last accepted start, and pending/held results.
    int         k8 = 0, k1 = 0;
    bit         act8 = 1'b0, act1 = 1'b0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic [8:0] hold8 = '0;
    logic [1:0] hold1 = '0;

    serial_adder #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
    );

    serial_adder #(.WIDTH(W1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of WIDTH=8 stimulus; acceptance decided from the model's own timeline.
    task automatic step8(input bit s, input logic [7:0] a, input logic [7:0] b);
        bit acc;
        start8 = s;
        a8     = a;
        b8     = b;
        acc    = s && (!act8 || (cyc + 1 > k8 + W8));
        tick();
        if (acc) begin
            act8 = 1'b1;
            k8   = cyc;
            q8.push_back({1'b0, a} + {1'b0, b});
        end
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
    endtask

    task automatic step1(input bit s, input logic a, input logic b);
        bit acc;
        start1 = s;
        a1     = a;
        b1     = b;
        acc    = s && (!act1 || (cyc + 1 > k1 + W1));
        tick();
        if (acc) begin
            act1 = 1'b1;
            k1   = cyc;
            q1.push_back({1'b0, a} + {1'b0, b});
        end
        start1 = 1'b0;
        a1     = 1'($urandom);
        b1     = 1'($urandom);
    endtask

    // Reset for one edge, optionally with start also high (reset must win).
    task automatic do_reset(input bit with_start);
        rst    = 1'b1;
        start8 = with_start;
        start1 = with_start;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        tick();
        rst    = 1'b0;
        start8 = 1'b0;
        start1 = 1'b0;
        act8   = 1'b0;
        act1   = 1'b0;
        q8.delete();
        q1.delete();
        hold8  = '0;
        hold1  = '0;
    endtask

    // Monitor: busy/done timing against the model, results popped from the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            check("busy8", 32'(busy8), 32'(act8 && cyc >= k8 && cyc < k8 + W8));
            check("done8", 32'(done8), 32'(act8 && cyc == k8 + W8));
            if (done8) begin
                if (q8.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL res8 at cycle %0d: got done with empty scoreboard", cyc);
                end else begin
                    hold8 = q8.pop_front();
                    check("res8", 32'({carry8, sum8}), 32'(hold8));
                end
            end else begin
                check("hold8", 32'({carry8, sum8}), 32'(hold8));
            end

            check("busy1", 32'(busy1), 32'(act1 && cyc >= k1 && cyc < k1 + W1));
            check("done1", 32'(done1), 32'(act1 && cyc == k1 + W1));
            if (done1) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL res1 at cycle %0d: got done with empty scoreboard", cyc);
                end else begin
                    hold1 = q1.pop_front();
                    check("res1", 32'({carry1, sum1}), 32'(hold1));
                end
            end else begin
                check("hold1", 32'({carry1, sum1}), 32'(hold1));
            end
        end
    end

    initial begin
        do_reset(1'b0);
        do_reset(1'b0);
        mon_en = 1'b1;

        // WIDTH=1 exhaustive half-adder table.
        for (int i = 0; i < 4; i++) begin
            step1(1'b1, i[1], i[0]);
            step1(1'b0, 1'b0, 1'b0);
            step1(1'b0, 1'b0, 1'b0);
        end
        // WIDTH=1 back-to-back starts, including one in the DONE cycle.
        for (int i = 0; i < 8; i++) step1(1'b1, 1'b1, 1'($urandom));

        // WIDTH=8 directed cases.
        step8(1'b1, 8'd3, 8'd5);
        repeat (10) step8(1'b0, 8'd0, 8'd0);
        step8(1'b1, 8'd255, 8'd1);
        repeat (10) step8(1'b0, 8'd0, 8'd0);
        step8(1'b1, 8'd255, 8'd255);
        repeat (10) step8(1'b0, 8'd0, 8'd0);
        step8(1'b1, 8'd170, 8'd85);
        repeat (10) step8(1'b0, 8'd0, 8'd0);

        // Start while busy is ignored; start in DONE is accepted.
        step8(1'b1, 8'd10, 8'd20);
        repeat (2) step8(1'b0, 8'd0, 8'd0);
        step8(1'b1, 8'd100, 8'd100);
        repeat (5) step8(1'b0, 8'd0, 8'd0);
        step8(1'b1, 8'd1, 8'd2);
        repeat (10) step8(1'b0, 8'd0, 8'd0);

        // Reset mid-RUN: no done, outputs cleared; start coinciding with rst is dropped.
        step8(1'b1, 8'd200, 8'd100);
        repeat (3) step8(1'b0, 8'd0, 8'd0);
        do_reset(1'b1);
        repeat (3) step8(1'b0, 8'd0, 8'd0);
        step8(1'b1, 8'd7, 8'd9);
        repeat (10) step8(1'b0, 8'd0, 8'd0);

        // Random operands and gaps; operands keep changing while busy.
        for (int n = 0; n < 1000; n++) begin
            step8(1'b1, 8'($urandom), 8'($urandom));
            repeat (W8 - 1 + $urandom_range(0, 3))
                step8(($urandom % 4) == 0, 8'($urandom), 8'($urandom));
        end
        repeat (12) step8(1'b0, 8'd0, 8'd0);

        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
